// File: rtl/my_clipper_pkg.sv
// Shared definitions for the clipper FIFO read adapter: the {eop, sop, data}
// word layout, the framing FSM encoding and the output buffer sizing rule.
package my_clipper_pkg;

  // Bit positions inside a FIFO word of a given payload width.
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int sop_bit(input int data_w);
    return data_w;
  endfunction

  function automatic int eop_bit(input int data_w);
    return data_w + 1;
  endfunction

  // The buffer must hold every read that can still be in flight plus the head.
  function automatic int buf_depth(input int rd_lat);
    return rd_lat + 1;
  endfunction

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/my_clipper_skid_buf.sv
// Circular DEPTH-entry buffer that catches FIFO read data. The head entry is
// always presented on rd_data; occ reports how many entries are held.
module my_clipper_skid_buf #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [OCC_W-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; a clear discards everything held.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized hardware.
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; occ gates its use, so stale contents
    // are never observed and the array can map onto plain registers or LUT RAM.
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/my_clipper_fifo_reader.sv
// Read-side adapter from the clipper line FIFO to an Avalon-ST video source.
// Reads are issued only when the skid buffer has a guaranteed slot for the
// returning data, so valid/ready backpressure can never drop or repeat a beat.
// Packet framing is checked on every accepted beat.
// Optional feature: define MY_CLIPPER_RD_STATS_EN to build the beat and frame
// counters; otherwise frame_cnt and beat_cnt are constant zero.
module my_clipper_fifo_reader
  import my_clipper_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W+1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              fifo_aclr,
  input  logic              flush,
  output logic [DATA_W-1:0] vst_data,
  output logic              vst_sop,
  output logic              vst_eop,
  output logic              vst_valid,
  input  logic              vst_ready,
  output logic              pkt_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int BUF_D  = buf_depth(RD_LAT);
  localparam int WORD_W = DATA_W + 2;
  localparam int OCC_W  = $clog2(BUF_D + 1);
  localparam int SUM_W  = OCC_W + 1;
  localparam int SOP_B  = sop_bit(DATA_W);
  localparam int EOP_B  = eop_bit(DATA_W);
  localparam int DATA_L = data_lsb();

  logic [RD_LAT-1:0] rd_sr;     // one bit per read still travelling through the FIFO
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occ;
  logic [WORD_W-1:0] head;
  logic [SUM_W-1:0]  used;
  logic [SUM_W-1:0]  limit;
  logic              pop;
  pkt_state_e        state;

  assign vst_valid = (occ != '0);
  assign pop       = vst_valid & vst_ready;
  assign vst_data  = head[DATA_W-1+DATA_L:DATA_L];
  assign vst_sop   = head[SOP_B];
  assign vst_eop   = head[EOP_B];

  // Count the reads whose data has not yet landed in the buffer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(rd_sr[i]);
  end

  // Credit check: buffered + in-flight beats after this cycle's pop must leave
  // room for one more read. The clear pulse also blocks reads so nothing is
  // fetched from a FIFO that is being emptied.
  assign used       = SUM_W'(occ) + SUM_W'(inflight);
  assign limit      = SUM_W'(RD_LAT) + SUM_W'(pop);
  assign fifo_rdreq = rst_n & ~fifo_aclr & ~fifo_empty & ~flush & (used <= limit);

  // Read-latency tracker: the bit leaving the top marks valid fifo_q this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) rd_sr <= '0;
    else                 rd_sr <= RD_LAT'({rd_sr, fifo_rdreq});
  end

  my_clipper_skid_buf #(
    .WIDTH (WORD_W),
    .DEPTH (BUF_D),
    .OCC_W (OCC_W)
  ) u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (rd_sr[RD_LAT-1]),
    .wr_data (fifo_q),
    .rd_en   (pop),
    .rd_data (head),
    .occ     (occ)
  );

  // Framing FSM with sticky error, plus the registered FIFO clear pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_aclr <= 1'b1;
      state     <= ST_IDLE;
      pkt_err   <= 1'b0;
    end else begin
      fifo_aclr <= flush;
      if (flush) begin
        state   <= ST_IDLE;
        pkt_err <= 1'b0;
      end else if (pop) begin
        case (state)
          ST_IDLE: begin
            if (!vst_sop)      pkt_err <= 1'b1;
            else if (!vst_eop) state   <= ST_IN_PKT;
          end
          ST_IN_PKT: begin
            // A sop here starts a new packet over the broken one.
            if (vst_sop)      pkt_err <= 1'b1;
            else if (vst_eop) state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MY_CLIPPER_RD_STATS_EN
  // Free-running statistics; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (vst_eop) frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign beat_cnt  = '0;
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_my_clipper_fifo_reader.sv
// Bench for my_clipper_fifo_reader: two instances (RD_LAT = 1 and 2) each read
// from a bench-side FIFO model. The expected output stream is the pushed input
// stream in order; framing and statistics follow the protocol rules directly.
module tb_my_clipper_fifo_reader;

  localparam int DW = 24;
  localparam int W  = DW + 2;
  localparam int CW = 16;
  localparam int N  = 2;          // instance g has RD_LAT = g+1, buffer depth g+2
  localparam logic [W-1:0] JUNK = '1;
`ifdef MY_CLIPPER_RD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic vst_ready = 1'b0;

  logic [N-1:0]         fifo_empty, fifo_rdreq, fifo_aclr;
  logic [N-1:0]         vst_sop, vst_eop, vst_valid, pkt_err;
  logic [N-1:0][W-1:0]  fifo_q;
  logic [N-1:0][DW-1:0] vst_data;
  logic [N-1:0][CW-1:0] frame_cnt, beat_cnt;

  // FIFO model and scoreboard state.
  logic [W-1:0] fmem [N][256];
  int           wr [N] = '{0, 0};   // written by the stimulus only
  int           rd [N] = '{0, 0};   // written by the FIFO model only
  int           sc [N] = '{0, 0};   // next expected output index (monitor only)
  logic [W-1:0] qpipe [N][3];

  // Protocol reference state (monitor only).
  bit           in_pkt [N];
  bit           m_err [N];
  int           m_beats [N];
  int           m_frames [N];
  int           outst [N];
  bit           stall_prev [N];
  logic [W-1:0] prev_head [N];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    my_clipper_fifo_reader #(
      .DATA_W (DW),
      .RD_LAT (g + 1),
      .CNT_W  (CW)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty[g]),
      .fifo_q     (fifo_q[g]),
      .fifo_rdreq (fifo_rdreq[g]),
      .fifo_aclr  (fifo_aclr[g]),
      .flush      (flush),
      .vst_data   (vst_data[g]),
      .vst_sop    (vst_sop[g]),
      .vst_eop    (vst_eop[g]),
      .vst_valid  (vst_valid[g]),
      .vst_ready  (vst_ready),
      .pkt_err    (pkt_err[g]),
      .frame_cnt  (frame_cnt[g]),
      .beat_cnt   (beat_cnt[g])
    );
    assign fifo_empty[g] = (rd[g] == wr[g]);
    assign fifo_q[g]     = qpipe[g][g];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // FIFO with RD_LAT-cycle read data; the clear empties it.
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (fifo_aclr[g])       rd[g] <= wr[g];
      else if (fifo_rdreq[g]) rd[g] <= rd[g] + 1;
      for (int i = 2; i > 0; i--) qpipe[g][i] <= qpipe[g][i-1];
      qpipe[g][0] <= (fifo_rdreq[g] && !fifo_aclr[g]) ? fmem[g][rd[g] & 255] : JUNK;
    end
  end

  // Monitor: compares outputs with the reference each cycle, then advances it.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!rst_n) begin
        in_pkt[g] = 0; m_err[g] = 0; m_beats[g] = 0; m_frames[g] = 0;
        outst[g] = 0; stall_prev[g] = 0; sc[g] = wr[g];
      end else begin
        logic [W-1:0] cur;
        bit pop;
        cur = {vst_eop[g], vst_sop[g], vst_data[g]};
        pop = vst_valid[g] && vst_ready;
        check($sformatf("pkt_err[%0d]", g), 64'(pkt_err[g]), 64'(m_err[g]));
        check($sformatf("beat_cnt[%0d]", g), 64'(beat_cnt[g]), STATS ? 64'(CW'(m_beats[g])) : 64'd0);
        check($sformatf("frame_cnt[%0d]", g), 64'(frame_cnt[g]), STATS ? 64'(CW'(m_frames[g])) : 64'd0);
        check($sformatf("outstanding[%0d]", g), 64'(outst[g] <= g + 2), 64'd1);
        if (stall_prev[g])
          check($sformatf("stall_hold[%0d]", g), {37'd0, vst_valid[g], cur}, {37'd0, 1'b1, prev_head[g]});
        if (pop) begin
          logic [W-1:0] exp_w;
          exp_w = fmem[g][sc[g] & 255];
          check($sformatf("pop_in_range[%0d]", g), 64'(sc[g] < wr[g]), 64'd1);
          check($sformatf("beat%0d[%0d]", sc[g], g), 64'(cur), 64'(exp_w));
          sc[g]++;
          m_beats[g]++;
          if (exp_w[DW+1]) m_frames[g]++;
          if (!in_pkt[g]) begin
            if (!exp_w[DW])          m_err[g] = 1;
            else if (!exp_w[DW+1])   in_pkt[g] = 1;
          end else begin
            if (exp_w[DW])           m_err[g] = 1;
            else if (exp_w[DW+1])    in_pkt[g] = 0;
          end
        end
        if (flush) begin
          in_pkt[g] = 0; m_err[g] = 0; outst[g] = 0;
        end else begin
          outst[g] = outst[g] + int'(fifo_rdreq[g]) - int'(pop);
        end
        if (fifo_aclr[g]) sc[g] = wr[g];
        stall_prev[g] = vst_valid[g] && !vst_ready && !flush;
        prev_head[g]  = cur;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic sop, input logic eop, input logic [DW-1:0] d);
    for (int g = 0; g < N; g++) begin
      fmem[g][wr[g] & 255] = {eop, sop, d};
      wr[g]++;
    end
  endtask

  task automatic drain(input string tag, input bit toggle);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      vst_ready = toggle ? ~vst_ready : 1'b1;
      step();
      done = 1;
      for (int g = 0; g < N; g++)
        if (sc[g] != wr[g] || rd[g] != wr[g] || vst_valid[g]) done = 0;
    end
    vst_ready = 1'b1;
    @(negedge clk);
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    int first [N];
    int last [N];
    int run [N];
    int pulses [N];

    // Reset state.
    step();
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_valid[%0d]", g), 64'(vst_valid[g]), 64'd0);
      check($sformatf("rst_rdreq[%0d]", g), 64'(fifo_rdreq[g]), 64'd0);
      check($sformatf("rst_aclr[%0d]", g), 64'(fifo_aclr[g]), 64'd1);
    end
    step(2);
    rst_n = 1'b1;
    step(2);

    // 1: eight preloaded beats, ready high: latency RD_LAT+1, then 8 in a row.
    vst_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_both(i == 0, i == 7, DW'($urandom));
    for (int g = 0; g < N; g++) begin first[g] = -1; last[g] = -1; run[g] = 0; end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++)
        if (vst_valid[g]) begin
          if (first[g] < 0) first[g] = i;
          last[g] = i;
          run[g]++;
        end
    end
    for (int g = 0; g < N; g++) begin
      check($sformatf("first_valid_cycle[%0d]", g), 64'(first[g]), 64'(g + 2));
      check($sformatf("beats_seen[%0d]", g), 64'(run[g]), 64'd8);
      check($sformatf("back_to_back[%0d]", g), 64'(last[g] - first[g] + 1), 64'd8);
      check($sformatf("beat_cnt8[%0d]", g), 64'(beat_cnt[g]), STATS ? 64'd8 : 64'd0);
    end
    step();

    // 2: sixteen random beats with ready toggling every cycle.
    for (int i = 0; i < 16; i++) push_both(i % 4 == 0, i % 4 == 3, DW'($urandom));
    drain("drain_toggle", 1'b1);
    step();

    // 3: ready low for 10 cycles: exactly BUF_D reads, then none.
    vst_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_both(i % 3 == 0, i % 3 == 2, DW'($urandom));
    for (int g = 0; g < N; g++) pulses[g] = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) pulses[g] += int'(fifo_rdreq[g]);
    end
    for (int g = 0; g < N; g++) begin
      check($sformatf("stall_reads[%0d]", g), 64'(pulses[g]), 64'(g + 2));
      check($sformatf("stall_rdreq_off[%0d]", g), 64'(fifo_rdreq[g]), 64'd0);
    end
    @(posedge clk); #1;
    vst_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < N; g++)
      check($sformatf("rdreq_resume[%0d]", g), 64'(fifo_rdreq[g]), 64'd1);
    drain("drain_stall", 1'b0);
    step();

    // 4: framing sop, eop, plain, sop, sop.
    for (int g = 0; g < N; g++) check($sformatf("err_clear_before[%0d]", g), 64'(pkt_err[g]), 64'd0);
    push_both(1'b1, 1'b0, DW'($urandom));
    push_both(1'b0, 1'b1, DW'($urandom));
    push_both(1'b0, 1'b0, DW'($urandom));
    push_both(1'b1, 1'b0, DW'($urandom));
    push_both(1'b1, 1'b0, DW'($urandom));
    drain("drain_framing", 1'b0);
    for (int g = 0; g < N; g++) begin
      check($sformatf("err_sticky[%0d]", g), 64'(pkt_err[g]), 64'd1);
      check($sformatf("frames_total[%0d]", g), 64'(frame_cnt[g]), STATS ? 64'd8 : 64'd0);
      check($sformatf("beats_total[%0d]", g), 64'(beat_cnt[g]), STATS ? 64'd35 : 64'd0);
    end
    step();

    // 5: flush mid-packet with reads in flight.
    vst_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_both(1'b0, 1'b0, DW'($urandom));
    step(2);
    flush = 1'b1;
    @(negedge clk);
    for (int g = 0; g < N; g++) check($sformatf("flush_rdreq[%0d]", g), 64'(fifo_rdreq[g]), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("flush_aclr_hi[%0d]", g), 64'(fifo_aclr[g]), 64'd1);
      check($sformatf("flush_valid[%0d]", g), 64'(vst_valid[g]), 64'd0);
      check($sformatf("flush_err[%0d]", g), 64'(pkt_err[g]), 64'd0);
    end
    step();
    vst_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < N; g++) check($sformatf("flush_aclr_lo[%0d]", g), 64'(fifo_aclr[g]), 64'd0);
    step(6);
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("flush_dropped[%0d]", g), 64'(vst_valid[g]), 64'd0);
      check($sformatf("flush_empty[%0d]", g), 64'(fifo_empty[g]), 64'd1);
    end
    step();

    // 6: reset in the middle of a stream (starts with a framing error).
    for (int i = 0; i < 10; i++) push_both(i % 5 == 1, i % 5 == 4, DW'($urandom));
    step(4);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("mid_rst_valid[%0d]", g), 64'(vst_valid[g]), 64'd0);
      check($sformatf("mid_rst_rdreq[%0d]", g), 64'(fifo_rdreq[g]), 64'd0);
      check($sformatf("mid_rst_aclr[%0d]", g), 64'(fifo_aclr[g]), 64'd1);
      check($sformatf("mid_rst_err[%0d]", g), 64'(pkt_err[g]), 64'd0);
      check($sformatf("mid_rst_beats[%0d]", g), 64'(beat_cnt[g]), 64'd0);
      check($sformatf("mid_rst_frames[%0d]", g), 64'(frame_cnt[g]), 64'd0);
    end
    step(2);
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++) push_both(i == 0, i == 3, DW'($urandom));
    drain("drain_restart", 1'b0);
    for (int g = 0; g < N; g++) begin
      check($sformatf("restart_beats[%0d]", g), 64'(beat_cnt[g]), STATS ? 64'd4 : 64'd0);
      check($sformatf("restart_frames[%0d]", g), 64'(frame_cnt[g]), STATS ? 64'd1 : 64'd0);
      check($sformatf("restart_err[%0d]", g), 64'(pkt_err[g]), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
